// File: rtl/wb_writeback.sv
// wb_writeback: register-file writeback arbitrating ALU results over buffered, extended load responses.
// Optional WB_LOAD_BYPASS_EN writes an accepted load straight to the port when the FIFO is empty and the ALU is idle.
module wb_writeback #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic                          w_alu_valid,
  input  logic [AWIDTH-1:0]             w_alu_rd,
  input  logic [DWIDTH-1:0]             w_alu_data,
  input  logic                          w_ld_valid,
  output logic                          w_ld_ready,
  input  logic [AWIDTH-1:0]             w_ld_rd,
  input  logic [DWIDTH-1:0]             w_ld_data,
  input  logic [2:0]                    w_ld_funct3,
  input  logic [1:0]                    w_ld_offset,
  output logic                          w_we,
  output logic [AWIDTH-1:0]             w_addr_rd,
  output logic [DWIDTH-1:0]             w_data_rd,
  output logic [(1<<AWIDTH)-1:0]        w_busy,
  output logic [$clog2(FIFO_DEPTH):0]   w_ld_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [AWIDTH-1:0] q_rd   [FIFO_DEPTH];
  logic [DWIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic alu_go, ld_acc, pop, push, byp;
  logic [DWIDTH-1:0] ld_ext;

  function automatic logic [DWIDTH-1:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [DWIDTH-1:0] d);
    logic [7:0] b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    return f3 == 3'b000 ? {{(DWIDTH-8){b[7]}}, b} :
           f3 == 3'b001 ? {{(DWIDTH-16){h[15]}}, h} :
           f3 == 3'b100 ? {{(DWIDTH-8){1'b0}}, b} :
           f3 == 3'b101 ? {{(DWIDTH-16){1'b0}}, h} : d;
  endfunction

  assign w_ld_ready = count < (PW+1)'(FIFO_DEPTH);
  assign w_ld_count = count;

  always_comb begin
    alu_go = w_alu_valid && w_alu_rd != '0;
    ld_acc = w_ld_valid && w_ld_ready;
    pop    = !alu_go && count != '0;
`ifdef WB_LOAD_BYPASS_EN
    byp    = ld_acc && w_ld_rd != '0 && count == '0 && !alu_go;
`else
    byp    = 1'b0;
`endif
    push   = ld_acc && w_ld_rd != '0 && !byp;
    ld_ext = extend(w_ld_funct3, w_ld_offset, w_ld_data);
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if ({1'b0, PW'(i - int'(rd_ptr))} < count) w_busy[q_rd[i]] = 1'b1;
  end

  always_ff @(posedge w_clk)
    if (push) begin
      q_rd[wr_ptr]   <= w_ld_rd;
      q_data[wr_ptr] <= ld_ext;
    end

  always_ff @(posedge w_clk or posedge w_rst)
    if (w_rst) begin
      w_we      <= 1'b0;
      w_addr_rd <= '0;
      w_data_rd <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      w_we      <= alu_go || pop || byp;
      w_addr_rd <= alu_go ? w_alu_rd : pop ? q_rd[rd_ptr] : byp ? w_ld_rd : w_addr_rd;
      w_data_rd <= alu_go ? w_alu_data : pop ? q_data[rd_ptr] : byp ? ld_ext : w_data_rd;
      wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count     <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
endmodule

// File: tb/tb_wb_writeback.sv
// tb_wb_writeback: randomized and directed checks of wb_writeback against a queue-based reference model.
module tb_wb_writeback;
  logic        w_clk = 0, w_rst = 1;
  logic        w_alu_valid = 0, w_ld_valid = 0;
  logic [4:0]  w_alu_rd = 0, w_ld_rd = 0;
  logic [31:0] w_alu_data = 0, w_ld_data = 0;
  logic [2:0]  w_ld_funct3 = 0;
  logic [1:0]  w_ld_offset = 0;
  logic        w_ld_ready, w_we;
  logic [4:0]  w_addr_rd;
  logic [31:0] w_data_rd, w_busy;
  logic [2:0]  w_ld_count;

  wb_writeback dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_alu_valid(w_alu_valid), .w_alu_rd(w_alu_rd),
    .w_alu_data(w_alu_data), .w_ld_valid(w_ld_valid), .w_ld_ready(w_ld_ready),
    .w_ld_rd(w_ld_rd), .w_ld_data(w_ld_data), .w_ld_funct3(w_ld_funct3),
    .w_ld_offset(w_ld_offset), .w_we(w_we), .w_addr_rd(w_addr_rd), .w_data_rd(w_data_rd),
    .w_busy(w_busy), .w_ld_count(w_ld_count)
  );

  always #5 w_clk = ~w_clk;

`ifdef WB_LOAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  logic        exp_we = 0;
  logic [4:0]  exp_addr = 0;
  logic [31:0] exp_data = 0;
  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * int'(off))) & 32'hFF;
    h = (d >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000: return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'b001: return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100: return b;
      3'b101: return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = 0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  // Called at posedge+1: drives inputs, checks live state, then checks the registered write after the edge.
  task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad, input bit lv,
                     input logic [4:0] lrd, input logic [31:0] ld, input logic [2:0] f3, input logic [1:0] off);
    bit acc, alu_go, pop, byp;
    w_alu_valid = av; w_alu_rd = ard; w_alu_data = ad;
    w_ld_valid = lv; w_ld_rd = lrd; w_ld_data = ld; w_ld_funct3 = f3; w_ld_offset = off;
    #1;
    check("ready", 32'(w_ld_ready), 32'(q.size() < 4));
    check("count", 32'(w_ld_count), 32'(q.size()));
    check("busy", w_busy, model_busy());
    acc = lv && q.size() < 4;
    alu_go = av && ard != 0;
    pop = !alu_go && q.size() > 0;
    byp = BYP && acc && lrd != 0 && q.size() == 0 && !alu_go;
    exp_we = alu_go || pop || byp;
    if (alu_go) begin exp_addr = ard; exp_data = ad; end
    else if (pop) begin exp_addr = q[0].rd; exp_data = q[0].d; end
    else if (byp) begin exp_addr = lrd; exp_data = ref_ext(f3, off, ld); end
    if (pop) void'(q.pop_front());
    if (acc && lrd != 0 && !byp) q.push_back('{rd: lrd, d: ref_ext(f3, off, ld)});
    @(posedge w_clk); #1;
    check("we", 32'(w_we), 32'(exp_we));
    check("addr", 32'(w_addr_rd), 32'(exp_addr));
    check("data", w_data_rd, exp_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ext_case(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp);
    cyc(0, 0, 0, 1, 5'd1, 32'h80F1_7F01, f3, off);
    idle(2);
    check("ext_data", w_data_rd, exp);
  endtask

  initial begin
    #1;
    check("rst_we", 32'(w_we), 0);
    check("rst_data", w_data_rd, 0);
    check("rst_ready", 32'(w_ld_ready), 1);
    @(posedge w_clk); #1 w_rst = 0;
    @(posedge w_clk); #1;

    cyc(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0);
    check("alu_we", 32'(w_we), 1);
    check("alu_addr", 32'(w_addr_rd), 5);
    check("alu_data", w_data_rd, 32'h1234_5678);
    cyc(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    check("alu_rd0_we", 32'(w_we), 0);

    ext_case(3'b000, 2'd3, 32'hFFFF_FF80);
    ext_case(3'b100, 2'd3, 32'h0000_0080);
    ext_case(3'b001, 2'd2, 32'hFFFF_80F1);
    ext_case(3'b101, 2'd0, 32'h0000_7F01);
    ext_case(3'b010, 2'd0, 32'h80F1_7F01);
    ext_case(3'b111, 2'd1, 32'h80F1_7F01);

    cyc(0, 0, 0, 1, 5'd7, 32'hDEAD_BEEF, 3'b010, 0);
    check("single_we1", 32'(w_we), 32'(BYP));
    check("single_busy7", 32'(w_busy[7]), 32'(!BYP));
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("single_we2", 32'(w_we), 32'(!BYP));
    check("single_data", w_data_rd, 32'hDEAD_BEEF);
    idle(1);

    // ALU starves loads until the FIFO fills, then full-with-pop holds off a new load for one cycle
    for (int i = 0; i < 6; i++)
      cyc(1, 5'd20, 32'(i), 1, 5'(8 + (i < 4 ? i : 4)), 32'(100 + (i < 4 ? i : 4)), 3'b010, 0);
    check("full_count", 32'(w_ld_count), 4);
    check("full_busy", w_busy, 32'h0000_0F00);
    cyc(0, 0, 0, 1, 5'd12, 32'd104, 3'b010, 0);
    check("pop_count", 32'(w_ld_count), 3);
    check("pop_addr", 32'(w_addr_rd), 8);
    cyc(1, 5'd21, 32'd55, 1, 5'd12, 32'd104, 3'b010, 0);
    check("refill_count", 32'(w_ld_count), 4);
    idle(6);
    check("drain_count", 32'(w_ld_count), 0);

    for (int i = 0; i < 3; i++) cyc(1, 5'd20, 32'(i), 1, 5'(1 + i), 32'(i), 3'b010, 0);
    w_alu_valid = 0; w_ld_valid = 0;
    #2 w_rst = 1;
    #1;
    q.delete(); exp_we = 0; exp_addr = 0; exp_data = 0;
    check("mrst_count", 32'(w_ld_count), 0);
    check("mrst_busy", w_busy, 0);
    check("mrst_we", 32'(w_we), 0);
    @(negedge w_clk) w_rst = 0;
    @(posedge w_clk); #1;
    idle(4);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] mb;
      bit av;
      logic [4:0] ard;
      mb = model_busy();
      av = 1'($urandom);
      ard = 5'($urandom);
      if (mb[ard]) av = 0;
      cyc(av, ard, $urandom, 1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_writeback.md
Name: wb_writeback

Overview:
- Writeback stage that owns the register-file write port (we / rd address / rd data) and drives it from two result sources.
- Source 1: single-cycle ALU results, which have no backpressure and always take priority.
- Source 2: load responses with a valid/ready handshake. They are buffered in a small FIFO, extended/aligned, and written when the port is free.
- Exports a per-register busy vector so decode can stall on pending load destinations.

Parameters:
- DWIDTH, 32: data width (load extension logic assumes 32).
- AWIDTH, 5: register address width; register count = 1<<AWIDTH.
- FIFO_DEPTH, 4: load buffer entries; power of two, >=2.

Ports:
- w_clk  input  1  clock; all state on rising edge.
- w_rst  input  1  asynchronous active-high reset.
- w_alu_valid  input  1  ALU result present this cycle.
- w_alu_rd  input  AWIDTH  ALU destination register.
- w_alu_data  input  DWIDTH  ALU result.
- w_ld_valid  input  1  load response valid.
- w_ld_ready  output  1  load buffer can accept.
- w_ld_rd  input  AWIDTH  load destination register.
- w_ld_data  input  DWIDTH  raw aligned memory word.
- w_ld_funct3  input  3  load type.
- w_ld_offset  input  2  byte address [1:0].
- w_we  output  1  register-file write enable.
- w_addr_rd  output  AWIDTH  write address.
- w_data_rd  output  DWIDTH  write data.
- w_busy  output  1<<AWIDTH  bit i=1 while a buffered load targets register i.
- w_ld_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, w_rst=1): w_we=0, w_addr_rd=0, w_data_rd=0, FIFO empty, w_ld_count=0, w_busy=0, w_ld_ready=1. The FIFO empties immediately even mid-stream; buffered loads are discarded.
- Load handshake: a load is accepted on an edge where w_ld_valid && w_ld_ready. w_ld_ready = (count < FIFO_DEPTH), combinational from count only. A pop in the same cycle does not raise ready when full.
- Accepted loads with w_ld_rd==0 are consumed but not pushed; count is unchanged.
- Push stores rd plus the extended data. Extension is done on entry:
  - 000 LB: sign-extend byte[offset].
  - 001 LH: sign-extend halfword[offset[1]].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte[offset].
  - 101 LHU: zero-extend halfword[offset[1]].
  - Any other funct3 is treated as LW.
  - LH/LHU ignore offset[0].
- Write-port arbitration, evaluated each cycle and registered onto w_we/w_addr_rd/w_data_rd at the next edge (1-cycle latency):
  - ALU: w_alu_valid && w_alu_rd!=0 → write ALU; the FIFO is not popped.
  - Otherwise, FIFO non-empty → pop head and write it.
  - Otherwise → w_we=0; w_addr_rd and w_data_rd hold their previous values.
- ALU results with rd==0 are dropped, and the FIFO may pop that cycle.
- Simultaneous push and pop: count unchanged; wrap-around pointers with an explicit count register.
- w_busy: OR over valid FIFO entries of the one-hot rd; combinational. An entry's bit clears in the cycle it pops; the register-file write-through covers the following read.
- Ordering precondition: upstream must not issue an ALU result to rd while w_busy[rd]=1 (WAW). Behaviour in that case is undefined and is not checked.
- Sustained ALU traffic starves loads. This is intended; upstream bounds it via w_ld_ready backpressure.

Optional Feature:
- Macro: WB_LOAD_BYPASS_EN.
- Defined: when the FIFO is empty, no eligible ALU write is present, and a load with rd!=0 is accepted, the load is written directly to the output registers at that edge (latency 1) and is not pushed. w_busy stays 0 for that load.
- Undefined: every accepted load with rd!=0 is pushed. Minimum load latency is 2 edges (push, then pop/write).

Test Plan:
- Reset mid-stream with 3 loads buffered → w_ld_count=0, w_busy=0, w_we=0, and no further writes of those loads.
- ALU rd=5 data=0x12345678, idle FIFO → next edge w_we=1, w_addr_rd=5, w_data_rd=0x12345678. ALU rd=0 → w_we=0.
- Load extension: word 0x80F17F01. LB off=3 → 0xFFFFFF80. LBU off=3 → 0x00000080. LH off=2 → 0xFFFF80F1. LHU off=0 → 0x00007F01. LW → 0x80F17F01.
- ALU valid every cycle for 6 cycles while 5 loads arrive → ready drops after 4 pushes (count=4). Loads drain in FIFO order once ALU stops. w_busy bits clear as each entry pops.
- Full FIFO with simultaneous pop and w_ld_valid → not accepted that cycle, accepted next cycle; count goes 4→3→4.
- Idle, single load rd=7 LW 0xDEADBEEF → w_we on 2nd edge without WB_LOAD_BYPASS_EN, on 1st edge with it; w_busy[7] pulses only without the macro.
